pipe_ctrl: RTL and testbench

//  Parametrised pipeline stall/flush controller; successor to the fixed 3-register control unit.

---
 rtl/pipe_ctrl_pkg.sv | 13 +
 rtl/pipe_ctrl_txn_tracker.sv | 68 ++++++
 rtl/pipe_ctrl.sv | 122 ++++++++++++
 tb/tb_pipe_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared stage indices and defaults for the pipeline controller
package pipe_ctrl_pkg;

   localparam int STG_IF = 0;
   localparam int STG_ID = 1;
   localparam int STG_EX = 2;
   localparam int STG_WB = 3;

   localparam logic [3:0] DEF_FLUSH_MASK = 4'b0011;

   typedef logic [31:0] cycle_cnt_t;

endpackage

// File: rtl/pipe_ctrl_txn_tracker.sv
// rtl/pipe_ctrl_txn_tracker.sv - outstanding/discard counters for one request-response bus
module pipe_ctrl_txn_tracker #(
   parameter int MAX_OUT     = 2,
   parameter int CNT_W       = 2,
   parameter int HAS_DISCARD = 1
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             req,
   input  logic             addr_ok,
   input  logic             data_ok,
   input  logic             flush,
   output logic [CNT_W-1:0] pend,
   output logic             allow,
   output logic             drop,
   output logic             err
);

   localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_OUT);
   localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;
   logic [CNT_W-1:0] disc;
   logic [CNT_W-1:0] disc_next;
   logic             accept;
   logic             err_q;

   assign accept = req && addr_ok;
   assign drop   = data_ok && (disc != '0);
   assign pend   = cnt - disc;
   assign allow  = cnt < MAX_C;
   assign err    = err_q;

   // Saturate at both ends so a misbehaving slave cannot wrap the count.
   always_comb begin
      cnt_next = cnt;
      if (accept && !data_ok) begin
         if (cnt != MAX_C) cnt_next = cnt + ONE_C;
      end else if (!accept && data_ok) begin
         if (cnt != '0) cnt_next = cnt - ONE_C;
      end
   end

   // A flush reloads with the post-cycle count, so responses still in flight are all orphaned.
   always_comb begin
      disc_next = disc;
      if (flush) begin
         disc_next = cnt_next;
      end else if (drop) begin
         disc_next = disc - ONE_C;
      end
      if (HAS_DISCARD == 0) disc_next = '0;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt   <= '0;
         disc  <= '0;
         err_q <= 1'b0;
      end else begin
         cnt   <= cnt_next;
         disc  <= disc_next;
         err_q <= err_q || (data_ok && (cnt == '0));
      end
   end

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush controller with bus transaction tracking
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int                NSTAGE     = 4,
   parameter int                DATA_STAGE = STG_EX,
   parameter int                MAX_OUT    = 2,
   parameter logic [NSTAGE-1:0] FLUSH_MASK = NSTAGE'(DEF_FLUSH_MASK)
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              inst_req,
   input  logic              inst_addr_ok,
   input  logic              inst_data_ok,
   input  logic              data_req,
   input  logic              data_addr_ok,
   input  logic              data_data_ok,
   input  logic [NSTAGE-1:0] stall_req,
   input  logic              flush_req,
   output logic [NSTAGE-1:0] stage_stall,
   output logic [NSTAGE-1:0] stage_refresh,
   output logic              inst_stall,
   output logic              inst_drop,
   output logic              inst_req_allow,
   output logic              data_req_allow,
   output logic              proto_err,
   output logic [31:0]       stall_cycles
);

   localparam int CNT_W = $clog2(MAX_OUT + 1);

   logic [CNT_W-1:0]  i_pend;
   logic [CNT_W-1:0]  d_pend;
   logic              i_allow;
   logic              d_allow;
   logic              i_drop;
   logic              d_drop;
   logic              i_err;
   logic              d_err;
   logic              inst_wait;
   logic [NSTAGE-1:0] src;
   logic [NSTAGE-1:0] stall_int;
   logic [NSTAGE-1:0] refresh_int;
   cycle_cnt_t        stall_cnt;

   pipe_ctrl_txn_tracker #(
      .MAX_OUT     (MAX_OUT),
      .CNT_W       (CNT_W),
      .HAS_DISCARD (1)
   ) u_inst_trk (
      .clk     (clk),
      .resetn  (resetn),
      .req     (inst_req),
      .addr_ok (inst_addr_ok),
      .data_ok (inst_data_ok),
      .flush   (flush_req),
      .pend    (i_pend),
      .allow   (i_allow),
      .drop    (i_drop),
      .err     (i_err)
   );

   pipe_ctrl_txn_tracker #(
      .MAX_OUT     (MAX_OUT),
      .CNT_W       (CNT_W),
      .HAS_DISCARD (0)
   ) u_data_trk (
      .clk     (clk),
      .resetn  (resetn),
      .req     (data_req),
      .addr_ok (data_addr_ok),
      .data_ok (data_data_ok),
      .flush   (flush_req),
      .pend    (d_pend),
      .allow   (d_allow),
      .drop    (d_drop),
      .err     (d_err)
   );

   // Fetch waits only on live (non-discarded) transactions; a dropped response does not satisfy it.
   assign inst_wait = (inst_req && !inst_addr_ok) ||
                      ((i_pend != '0) && !(inst_data_ok && !i_drop));

   always_comb begin
      src               = stall_req;
      src[0]            = src[0] | inst_wait;
      src[DATA_STAGE]   = src[DATA_STAGE] | (data_req && !data_addr_ok);
      src[DATA_STAGE+1] = src[DATA_STAGE+1] | ((d_pend != '0) && !(data_data_ok && !d_drop));
   end

   genvar i;
   generate
      for (i = 0; i < NSTAGE; i++) begin : g_stage
         assign stall_int[i] = (|src[NSTAGE-1:i]) && !(flush_req && FLUSH_MASK[i]);
         if (i == 0) begin : g_first
            assign refresh_int[i] = flush_req && FLUSH_MASK[i];
         end else begin : g_rest
            // Bubble goes in where a held register stops feeding a moving one.
            assign refresh_int[i] = (flush_req && FLUSH_MASK[i]) ||
                                    (stall_int[i-1] && !stall_int[i]);
         end
      end
   endgenerate

   assign stage_stall    = resetn ? stall_int : '0;
   assign stage_refresh  = resetn ? refresh_int : '1;
   assign inst_stall     = resetn && inst_wait;
   assign inst_drop      = resetn && i_drop;
   assign inst_req_allow = resetn && i_allow;
   assign data_req_allow = resetn && d_allow;
   assign proto_err      = i_err || d_err;
   assign stall_cycles   = stall_cnt;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         stall_cnt <= '0;
      end else if (stall_int[0]) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - self-checking bench for pipe_ctrl
module tb_pipe_ctrl;

   localparam int         MAXO = 2;
   localparam logic [3:0] MASK = 4'b0011;

   logic        clk;
   logic        resetn;
   logic        inst_req, inst_addr_ok, inst_data_ok;
   logic        data_req, data_addr_ok, data_data_ok;
   logic [3:0]  stall_req;
   logic        flush_req;
   logic [3:0]  stage_stall, stage_refresh;
   logic        inst_stall, inst_drop, inst_req_allow, data_req_allow, proto_err;
   logic [31:0] stall_cycles;

   int checks = 0;
   int errors = 0;

   int          m_icnt, m_idisc, m_dcnt;
   int          n_icnt, n_idisc, n_dcnt;
   bit          m_err, n_err;
   int unsigned m_scyc, n_scyc;

   typedef struct packed {
      logic       ireq, iaok, dreq, daok;
      logic [3:0] sreq;
      logic       flush;
      logic [3:0] e_stall, e_ref;
      logic       e_istall;
   } vec_t;

   vec_t tbl [10];

   pipe_ctrl #(
      .NSTAGE     (4),
      .DATA_STAGE (2),
      .MAX_OUT    (MAXO),
      .FLUSH_MASK (MASK)
   ) dut (
      .clk            (clk),
      .resetn         (resetn),
      .inst_req       (inst_req),
      .inst_addr_ok   (inst_addr_ok),
      .inst_data_ok   (inst_data_ok),
      .data_req       (data_req),
      .data_addr_ok   (data_addr_ok),
      .data_data_ok   (data_data_ok),
      .stall_req      (stall_req),
      .flush_req      (flush_req),
      .stage_stall    (stage_stall),
      .stage_refresh  (stage_refresh),
      .inst_stall     (inst_stall),
      .inst_drop      (inst_drop),
      .inst_req_allow (inst_req_allow),
      .data_req_allow (data_req_allow),
      .proto_err      (proto_err),
      .stall_cycles   (stall_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic int clamp(input int v);
      if (v < 0) return 0;
      if (v > MAXO) return MAXO;
      return v;
   endfunction

   task automatic idle_inputs();
      inst_req = 0; inst_addr_ok = 0; inst_data_ok = 0;
      data_req = 0; data_addr_ok = 0; data_data_ok = 0;
      stall_req = 4'b0000; flush_req = 0;
   endtask

   // Reference model: outstanding counts as integers, outputs straight from the behavioural rules.
   task automatic settle();
      bit [3:0] src, es, er;
      bit [3:0] mk;
      bit       drop, istall;
      @(negedge clk);
      mk = MASK;
      if (!resetn) begin
         m_icnt = 0; m_idisc = 0; m_dcnt = 0; m_err = 0; m_scyc = 0;
         n_icnt = 0; n_idisc = 0; n_dcnt = 0; n_err = 0; n_scyc = 0;
         chk("rst_stage_stall", 32'(stage_stall), 32'h0);
         chk("rst_stage_refresh", 32'(stage_refresh), 32'hF);
         chk("rst_inst_stall", 32'(inst_stall), 32'h0);
         chk("rst_inst_drop", 32'(inst_drop), 32'h0);
         chk("rst_inst_allow", 32'(inst_req_allow), 32'h0);
         chk("rst_data_allow", 32'(data_req_allow), 32'h0);
         chk("rst_proto_err", 32'(proto_err), 32'h0);
         chk("rst_stall_cycles", stall_cycles, 32'h0);
      end else begin
         drop   = inst_data_ok && (m_idisc > 0);
         istall = (inst_req && !inst_addr_ok) ||
                  ((m_icnt - m_idisc) != 0 && !(inst_data_ok && !drop));
         src = stall_req;
         if (istall) src[0] = 1'b1;
         if (data_req && !data_addr_ok) src[2] = 1'b1;
         if (m_dcnt > 0 && !data_data_ok) src[3] = 1'b1;
         for (int i = 0; i < 4; i++)
            es[i] = ((src >> i) != 4'b0) && !(flush_req && mk[i]);
         for (int i = 0; i < 4; i++)
            er[i] = (flush_req && mk[i]) || (i > 0 && es[i-1] && !es[i]);
         chk("m_stage_stall", 32'(stage_stall), 32'(es));
         chk("m_stage_refresh", 32'(stage_refresh), 32'(er));
         chk("m_inst_stall", 32'(inst_stall), 32'(istall));
         chk("m_inst_drop", 32'(inst_drop), 32'(drop));
         chk("m_inst_allow", 32'(inst_req_allow), 32'(m_icnt < MAXO));
         chk("m_data_allow", 32'(data_req_allow), 32'(m_dcnt < MAXO));
         chk("m_proto_err", 32'(proto_err), 32'(m_err));
         chk("m_stall_cycles", stall_cycles, m_scyc);
         n_icnt  = clamp(m_icnt + int'(inst_req && inst_addr_ok) - int'(inst_data_ok));
         n_idisc = flush_req ? n_icnt : m_idisc - int'(drop);
         n_dcnt  = clamp(m_dcnt + int'(data_req && data_addr_ok) - int'(data_data_ok));
         n_err   = m_err || (inst_data_ok && m_icnt == 0) || (data_data_ok && m_dcnt == 0);
         n_scyc  = m_scyc + 32'(es[0]);
      end
   endtask

   task automatic advance();
      @(posedge clk);
      m_icnt = n_icnt; m_idisc = n_idisc; m_dcnt = n_dcnt; m_err = n_err; m_scyc = n_scyc;
      #1;
   endtask

   task automatic cyc();
      settle();
      advance();
   endtask

   task automatic do_reset();
      resetn = 0;
      idle_inputs();
      settle();
      advance();
      resetn = 1;
   endtask

   initial begin
      resetn = 0;
      idle_inputs();
      //                ireq iaok dreq daok sreq    fl  e_stall  e_ref    e_ist
      tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 4'b0001, 4'b0010, 1'b0};
      tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b0, 4'b0111, 4'b1000, 1'b0};
      tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b0, 4'b1111, 4'b0000, 1'b0};
      tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0001, 4'b0010, 1'b1};
      tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0111, 4'b1000, 1'b0};
      tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b0000, 4'b0011, 1'b0};
      tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b1, 4'b0100, 4'b1011, 1'b0};
      tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b1, 4'b1100, 4'b0011, 1'b0};
      tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b0, 4'b0011, 4'b0100, 1'b0};
      tbl[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0};

      // Reset with busy-looking inputs, then idle
      stall_req = 4'b1111; inst_req = 1; data_req = 1; flush_req = 1;
      settle();
      chk("t1_refresh_in_reset", 32'(stage_refresh), 32'hF);
      advance();
      resetn = 1;
      idle_inputs();
      settle();
      chk("t1_idle_stall", 32'(stage_stall), 32'h0);
      chk("t1_idle_inst_allow", 32'(inst_req_allow), 32'h1);
      chk("t1_idle_data_allow", 32'(data_req_allow), 32'h1);
      chk("t1_idle_err", 32'(proto_err), 32'h0);
      advance();

      // Combinational stall/refresh table from an idle bus
      for (int k = 0; k < 10; k++) begin
         idle_inputs();
         inst_req = tbl[k].ireq; inst_addr_ok = tbl[k].iaok;
         data_req = tbl[k].dreq; data_addr_ok = tbl[k].daok;
         stall_req = tbl[k].sreq; flush_req = tbl[k].flush;
         settle();
         chk($sformatf("tbl%0d_stall", k), 32'(stage_stall), 32'(tbl[k].e_stall));
         chk($sformatf("tbl%0d_refresh", k), 32'(stage_refresh), 32'(tbl[k].e_ref));
         chk($sformatf("tbl%0d_inst_stall", k), 32'(inst_stall), 32'(tbl[k].e_istall));
         advance();
      end

      // Two accepts fill the inst bus; accept+response together keeps it full
      do_reset();
      idle_inputs(); inst_req = 1; inst_addr_ok = 1;
      cyc();
      cyc();
      inst_data_ok = 1;
      settle();
      chk("t2_allow_full", 32'(inst_req_allow), 32'h0);
      advance();
      idle_inputs();
      settle();
      chk("t2_allow_still_full", 32'(inst_req_allow), 32'h0);
      advance();

      // Flush with two in flight: both responses dropped, the next one kept
      flush_req = 1;
      settle();
      chk("t3_flush_refresh", 32'(stage_refresh), 32'h3);
      advance();
      idle_inputs(); inst_req = 1; inst_data_ok = 1;
      for (int k = 0; k < 2; k++) begin
         settle();
         chk("t3_drop", 32'(inst_drop), 32'h1);
         chk("t3_inst_stall_held", 32'(inst_stall), 32'h1);
         advance();
      end
      idle_inputs(); inst_req = 1; inst_addr_ok = 1;
      cyc();
      idle_inputs(); inst_data_ok = 1;
      settle();
      chk("t3_third_not_dropped", 32'(inst_drop), 32'h0);
      chk("t3_third_no_stall", 32'(inst_stall), 32'h0);
      advance();

      // Data address wait, then outstanding data response
      do_reset();
      idle_inputs(); data_req = 1;
      for (int k = 0; k < 3; k++) begin
         settle();
         chk("t5_addr_wait", 32'(stage_stall), 32'h7);
         advance();
      end
      data_addr_ok = 1;
      cyc();
      idle_inputs();
      for (int k = 0; k < 2; k++) begin
         settle();
         chk("t5_data_wait", 32'(stage_stall), 32'hF);
         advance();
      end
      data_data_ok = 1;
      settle();
      chk("t5_data_done", 32'(stage_stall), 32'h0);
      advance();

      // Orphan data response sets sticky error
      do_reset();
      idle_inputs(); data_data_ok = 1;
      settle();
      chk("t6_err_same_cycle", 32'(proto_err), 32'h0);
      advance();
      idle_inputs();
      for (int k = 0; k < 3; k++) begin
         settle();
         chk("t6_err_sticky", 32'(proto_err), 32'h1);
         advance();
      end
      resetn = 0;
      settle();
      chk("t6_err_cleared", 32'(proto_err), 32'h0);
      advance();
      resetn = 1;

      // Random traffic against the model
      for (int k = 0; k < 4000; k++) begin
         resetn       = ($urandom_range(0, 199) != 0);
         inst_req     = $urandom_range(0, 1) == 1;
         inst_addr_ok = $urandom_range(0, 1) == 1;
         inst_data_ok = $urandom_range(0, 2) == 0;
         data_req     = $urandom_range(0, 1) == 1;
         data_addr_ok = $urandom_range(0, 1) == 1;
         data_data_ok = $urandom_range(0, 2) == 0;
         for (int b = 0; b < 4; b++) stall_req[b] = ($urandom_range(0, 7) == 0);
         flush_req    = ($urandom_range(0, 11) == 0);
         cyc();
      end
      resetn = 1;
      idle_inputs();
      cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
